// File: rtl/refresh_scheduler_pkg.sv
// Shared types and constants for the DRAM refresh scheduler.
// Holds the scheduler state encoding, the REFRESH pin pattern and default timing.
package refresh_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED,
    ST_IDLE,
    ST_POSTPONE,
    ST_REQUEST,
    ST_URGENT
  } ref_state_e;

  // {cs, ras, cas, we}; all pins are active low
  localparam logic [3:0] REF_CMD_PINS = 4'b0001;

  localparam int TREFI_DEF         = 780;
  localparam int MAX_PENDING_DEF   = 8;
  localparam int URGENT_THRESH_DEF = 4;

  function automatic logic is_ref_cmd(input logic cs, input logic ras,
                                      input logic cas, input logic we);
    return {cs, ras, cas, we} == REF_CMD_PINS;
  endfunction

endpackage

// File: rtl/refresh_scheduler_if.sv
// Command-bus snoop and arbiter handshake between the controller and the refresh scheduler.
// The controller side is the master; the scheduler is the slave.
interface refresh_scheduler_if;
  logic cmd_cs;
  logic cmd_ras;
  logic cmd_cas;
  logic cmd_we;
  logic host_busy;
  logic refresh_signal;
  logic refresh_urgent;

  modport master (
    output cmd_cs, cmd_ras, cmd_cas, cmd_we, host_busy,
    input  refresh_signal, refresh_urgent
  );

  modport slave (
    input  cmd_cs, cmd_ras, cmd_cas, cmd_we, host_busy,
    output refresh_signal, refresh_urgent
  );
endinterface

// File: rtl/refresh_scheduler_timer.sv
// tREFI interval timer: counts enabled cycles 0..TREFI-1 and flags the last one.
// Holds its value while disabled; clr returns it to 0.
module refresh_scheduler_timer
  import refresh_scheduler_pkg::*;
#(
  parameter int TREFI = TREFI_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TREFI);
  localparam logic [CW-1:0] LAST = CW'(TREFI - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/refresh_scheduler.sv
// Refresh credit scheduler: earns one credit per tREFI, retires one per snooped REFRESH,
// and requests/forces refresh depending on owed credits and host traffic.
module refresh_scheduler
  import refresh_scheduler_pkg::*;
#(
  parameter int TREFI         = TREFI_DEF,
  parameter int MAX_PENDING   = MAX_PENDING_DEF,
  parameter int URGENT_THRESH = URGENT_THRESH_DEF,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_done,
  input  logic                 refresh_en,
  refresh_scheduler_if.slave   bus,
  output logic [3:0]           pending_count,
  output logic                 overflow_err,
  output logic [CNT_W-1:0]     refresh_total
);

  localparam logic [3:0]       MAX_P   = 4'(MAX_PENDING);
  localparam logic [3:0]       URG_T   = 4'(URGENT_THRESH);
  localparam logic [CNT_W-1:0] TOT_ONE = CNT_W'(1);

  ref_state_e state;
  logic       en;
  logic       tick;
  logic       ref_cmd;
  logic [3:0] pend_nxt;

  assign en      = init_done & refresh_en;
  assign ref_cmd = is_ref_cmd(bus.cmd_cs, bus.cmd_ras, bus.cmd_cas, bus.cmd_we);

  refresh_scheduler_timer #(.TREFI(TREFI)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!init_done),
    .en    (en),
    .tick  (tick)
  );

  // Earn and retire in the same cycle cancel; both ends of the range hold.
  function automatic logic [3:0] pend_update(input logic [3:0] p, input logic inc,
                                             input logic dec);
    if (inc && !dec) return (p == MAX_P) ? p : p + 4'd1;
    if (dec && !inc) return (p == 4'd0)  ? p : p - 4'd1;
    return p;
  endfunction

  function automatic ref_state_e serve_state(input logic [3:0] p, input logic busy);
    if (p == 4'd0)  return ST_IDLE;
    if (p >= URG_T) return ST_URGENT;
    return busy ? ST_POSTPONE : ST_REQUEST;
  endfunction

  assign pend_nxt = init_done ? pend_update(pending_count, tick, ref_cmd) : 4'd0;

  // Decisions use the post-update credit count; outputs follow the state one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_DISABLED;
      pending_count      <= 4'd0;
      overflow_err       <= 1'b0;
      refresh_total      <= '0;
      bus.refresh_signal <= 1'b0;
      bus.refresh_urgent <= 1'b0;
    end else begin
      pending_count <= pend_nxt;
      if (tick && !ref_cmd && pending_count == MAX_P) overflow_err <= 1'b1;
      if (ref_cmd && state != ST_DISABLED) refresh_total <= refresh_total + TOT_ONE;

      bus.refresh_signal <= en && (state == ST_REQUEST || state == ST_URGENT);
      bus.refresh_urgent <= en && (state == ST_URGENT);

      if (!init_done)                             state <= ST_DISABLED;
      else if (state == ST_DISABLED || !refresh_en) state <= ST_IDLE;
      else                                        state <= serve_state(pend_nxt, bus.host_busy);
    end
  end

endmodule

// File: tb/tb_refresh_scheduler.sv
// Self-checking bench for refresh_scheduler: directed scenarios plus randomized traffic
// compared against a credit/interval reference model.
module tb_refresh_scheduler;

  localparam int TREFI = 20;
  localparam int MAXP  = 8;
  localparam int UT    = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done = 1'b0;
  logic refresh_en = 1'b0;
  logic [3:0]       pending_count;
  logic             overflow_err;
  logic [CNT_W-1:0] refresh_total;

  refresh_scheduler_if bus();

  refresh_scheduler #(
    .TREFI(TREFI), .MAX_PENDING(MAXP), .URGENT_THRESH(UT), .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .init_done     (init_done),
    .refresh_en    (refresh_en),
    .bus           (bus),
    .pending_count (pending_count),
    .overflow_err  (overflow_err),
    .refresh_total (refresh_total)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: interval count, owed credits, and the serve decision taken at each edge.
  int m_cnt = 0, m_pend = 0, m_total = 0;
  bit m_ovf = 0, m_sig = 0, m_urg = 0, m_ready = 0, m_req = 0, m_ugs = 0;
  int n_cnt, n_pend;
  bit n_tick, n_rc, n_en;

  always_comb begin
    n_en   = init_done && refresh_en;
    n_rc   = !bus.cmd_cs && !bus.cmd_ras && !bus.cmd_cas && bus.cmd_we;
    n_tick = n_en && (m_cnt == TREFI - 1);
    n_cnt  = !init_done ? 0 : (n_en ? (m_cnt + 1) % TREFI : m_cnt);
    n_pend = m_pend;
    if (!init_done)            n_pend = 0;
    else if (n_tick && !n_rc)  n_pend = (m_pend < MAXP) ? m_pend + 1 : m_pend;
    else if (n_rc && !n_tick)  n_pend = (m_pend > 0) ? m_pend - 1 : 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_pend <= 0; m_total <= 0;
      m_ovf <= 0; m_sig <= 0; m_urg <= 0; m_ready <= 0; m_req <= 0; m_ugs <= 0;
    end else begin
      m_cnt  <= n_cnt;
      m_pend <= n_pend;
      if (n_tick && !n_rc && m_pend == MAXP) m_ovf <= 1;
      if (n_rc && m_ready) m_total <= (m_total + 1) % (1 << CNT_W);
      m_sig   <= n_en && m_req;
      m_urg   <= n_en && m_ugs;
      m_req   <= m_ready && n_en && n_pend > 0 && (n_pend >= UT || !bus.host_busy);
      m_ugs   <= m_ready && n_en && n_pend >= UT;
      m_ready <= init_done;
    end
  end

  logic [CNT_W+6:0] obs, expv;
  assign obs  = {bus.refresh_signal, bus.refresh_urgent, overflow_err, pending_count, refresh_total};
  assign expv = {m_sig, m_urg, m_ovf, 4'(m_pend), CNT_W'(m_total)};

  task automatic set_cmd(input bit r);
    {bus.cmd_cs, bus.cmd_ras, bus.cmd_cas, bus.cmd_we} = r ? 4'b0001 : 4'b1111;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init_done = 1'b0; refresh_en = 1'b0; bus.host_busy = 1'b0; set_cmd(0);
    repeat (3) @(negedge clk);
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL reset_state: got %h want 0", obs); end
    rst_n = 1'b1;
    set_cmd(1);
    @(negedge clk);
    set_cmd(0);
    repeat (2) @(negedge clk);
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL disabled_ignores_cmd: got %h want 0", obs); end
  endtask

  task automatic test_first_refresh();
    init_done = 1'b1; refresh_en = 1'b1; bus.host_busy = 1'b0;
    repeat (19) begin
      @(negedge clk);
      n_cmp++; if (obs !== expv) begin n_bad++; $display("FAIL first_interval: got %h want %h", obs, expv); end
    end
    n_cmp++; if (pending_count !== 4'd0) begin n_bad++; $display("FAIL pre_tick_pending: got %0d want 0", pending_count); end
    @(negedge clk);
    n_cmp++; if ({pending_count, bus.refresh_signal} !== {4'd1, 1'b0}) begin
      n_bad++; $display("FAIL tick20_pending: got %0d/%b want 1/0", pending_count, bus.refresh_signal); end
    @(negedge clk);
    n_cmp++; if (bus.refresh_signal !== 1'b1) begin n_bad++; $display("FAIL signal_raise: got %b want 1", bus.refresh_signal); end
    set_cmd(1);
    @(negedge clk);
    set_cmd(0);
    @(negedge clk);
    n_cmp++; if ({pending_count, bus.refresh_signal, refresh_total} !== {4'd0, 1'b0, 16'd1}) begin
      n_bad++; $display("FAIL served: got %0d/%b/%0d want 0/0/1", pending_count, bus.refresh_signal, refresh_total); end
  endtask

  task automatic test_postpone_urgent();
    bus.host_busy = 1'b1;
    for (int i = 0; i < 200 && m_pend < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (obs !== expv) begin n_bad++; $display("FAIL postpone_track: got %h want %h", obs, expv); end
      n_cmp++; if (bus.refresh_signal !== 1'b0) begin n_bad++; $display("FAIL postpone_quiet: got %b want 0", bus.refresh_signal); end
    end
    n_cmp++; if (m_pend != 4) begin n_bad++; $display("FAIL postpone_timeout: got %0d want 4", m_pend); end
    @(negedge clk);
    n_cmp++; if ({pending_count, bus.refresh_signal, bus.refresh_urgent} !== {4'd4, 2'b11}) begin
      n_bad++; $display("FAIL urgent_raise: got %0d/%b%b want 4/11", pending_count, bus.refresh_signal, bus.refresh_urgent); end
    set_cmd(1);
    @(negedge clk);
    set_cmd(0);
    @(negedge clk);
    n_cmp++; if ({pending_count, bus.refresh_signal, bus.refresh_urgent} !== {4'd3, 2'b00}) begin
      n_bad++; $display("FAIL urgent_drop: got %0d/%b%b want 3/00", pending_count, bus.refresh_signal, bus.refresh_urgent); end
  endtask

  task automatic test_overflow();
    bus.host_busy = 1'b1;
    for (int i = 0; i < 400 && !m_ovf; i++) begin
      @(negedge clk);
      n_cmp++; if (obs !== expv) begin n_bad++; $display("FAIL overflow_track: got %h want %h", obs, expv); end
    end
    n_cmp++; if ({overflow_err, pending_count} !== {1'b1, 4'd8}) begin
      n_bad++; $display("FAIL overflow_sat: got %b/%0d want 1/8", overflow_err, pending_count); end
    bus.host_busy = 1'b0;
    repeat (12) begin
      set_cmd(1);
      @(negedge clk);
      n_cmp++; if (obs !== expv) begin n_bad++; $display("FAIL drain_track: got %h want %h", obs, expv); end
    end
    set_cmd(0);
    n_cmp++; if ({overflow_err, pending_count} !== {1'b1, 4'd0}) begin
      n_bad++; $display("FAIL overflow_sticky: got %b/%0d want 1/0", overflow_err, pending_count); end
  endtask

  task automatic test_tick_and_cmd();
    int want_tot;
    bus.host_busy = 1'b1;
    for (int i = 0; i < 150 && !(m_pend == 2 && m_cnt == TREFI - 1); i++) begin
      @(negedge clk);
      n_cmp++; if (obs !== expv) begin n_bad++; $display("FAIL align_track: got %h want %h", obs, expv); end
    end
    n_cmp++; if (!(m_pend == 2 && m_cnt == TREFI - 1)) begin
      n_bad++; $display("FAIL align_timeout: got pend %0d cnt %0d want 2/%0d", m_pend, m_cnt, TREFI - 1); end
    want_tot = (m_total + 1) % (1 << CNT_W);
    set_cmd(1);
    @(negedge clk);
    set_cmd(0);
    n_cmp++; if ({pending_count, refresh_total} !== {4'd2, CNT_W'(want_tot)}) begin
      n_bad++; $display("FAIL tick_cmd_cancel: got %0d/%0d want 2/%0d", pending_count, refresh_total, want_tot); end
  endtask

  task automatic test_refresh_en();
    int c, k;
    bus.host_busy = 1'b0;
    set_cmd(1);
    @(negedge clk);
    set_cmd(0);
    refresh_en = 1'b0;
    c = m_cnt;
    repeat (50) begin
      @(negedge clk);
      n_cmp++; if (obs !== expv) begin n_bad++; $display("FAIL paused_track: got %h want %h", obs, expv); end
    end
    n_cmp++; if ({pending_count, bus.refresh_signal, bus.refresh_urgent} !== {4'd1, 2'b00}) begin
      n_bad++; $display("FAIL paused_state: got %0d/%b%b want 1/00", pending_count, bus.refresh_signal, bus.refresh_urgent); end
    refresh_en = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.refresh_signal !== 1'b0) begin n_bad++; $display("FAIL resume_edge1: got %b want 0", bus.refresh_signal); end
    @(negedge clk);
    n_cmp++; if (bus.refresh_signal !== 1'b1) begin n_bad++; $display("FAIL resume_edge2: got %b want 1", bus.refresh_signal); end
    k = 2;
    while (pending_count !== 4'd2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_cmp++; if (k != TREFI - c) begin n_bad++; $display("FAIL resume_tick: got %0d cycles want %0d", k, TREFI - c); end
  endtask

  task automatic test_init_drop();
    bus.host_busy = 1'b1;
    for (int i = 0; i < 100 && m_pend != 3; i++) begin
      @(negedge clk);
      n_cmp++; if (obs !== expv) begin n_bad++; $display("FAIL predrop_track: got %h want %h", obs, expv); end
    end
    init_done = 1'b0;
    @(negedge clk);
    n_cmp++; if ({pending_count, bus.refresh_signal, bus.refresh_urgent} !== {4'd0, 2'b00}) begin
      n_bad++; $display("FAIL init_drop: got %0d/%b%b want 0/00", pending_count, bus.refresh_signal, bus.refresh_urgent); end
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (obs !== expv) begin n_bad++; $display("FAIL disabled_track: got %h want %h", obs, expv); end
    end
    init_done = 1'b1;
  endtask

  task automatic test_async_reset();
    bus.host_busy = 1'b0;
    repeat (30) begin
      @(negedge clk);
      n_cmp++; if (obs !== expv) begin n_bad++; $display("FAIL prereset_track: got %h want %h", obs, expv); end
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL async_reset: got %h want 0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (obs !== expv) begin n_bad++; $display("FAIL postreset_track: got %h want %h", obs, expv); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bus.host_busy = 1'($urandom_range(0, 1));
      refresh_en    = ($urandom_range(0, 19) != 0);
      init_done     = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, ((i / 300) % 2 == 1) ? 4 : 40) == 0)
        {bus.cmd_cs, bus.cmd_ras, bus.cmd_cas, bus.cmd_we} = 4'b0001;
      else
        {bus.cmd_cs, bus.cmd_ras, bus.cmd_cas, bus.cmd_we} = 4'($urandom);
      @(negedge clk);
      n_cmp++; if (obs !== expv) begin n_bad++; $display("FAIL random_track cyc %0d: got %h want %h", i, obs, expv); end
    end
    set_cmd(0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_first_refresh();
    test_postpone_urgent();
    test_overflow();
    test_tick_and_cmd();
    test_refresh_en();
    test_init_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
